// File: rtl/cola_buyer_fsm.sv
// Customer-side coin payer for the cola vending machine: pays PRICE in coin pulses, then waits for cola/change.
// Optional per-coin and per-cola statistics counters are built when COIN_STAT_EN is defined.
module cola_buyer_fsm #(
  parameter int unsigned PRICE   = 5,
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        buy_req,
  input  logic [1:0]  pay_mode,
  input  logic        pi_cola,
  input  logic        pi_money,
  output logic        po_money_half,
  output logic        po_money_one,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        change_rcvd,
  output logic [4:0]  paid_units,
  output logic [15:0] stat_half_cnt,
  output logic [15:0] stat_one_cnt,
  output logic [15:0] stat_cola_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COIN,
    S_GAP,
    S_WAIT_COLA,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [3:0]  remaining_q, remaining_d;
  logic [4:0]  paid_q, paid_d;
  logic [3:0]  gap_q, gap_d;
  logic [7:0]  timer_q, timer_d;
  logic        chg_flag_q, chg_flag_d;
  logic        chg_rcvd_q, chg_rcvd_d;

  logic        one_sel;
  logic [3:0]  coin_rem;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      remaining_q <= 4'd0;
      paid_q      <= 5'd0;
      gap_q       <= 4'd0;
      timer_q     <= 8'd0;
      chg_flag_q  <= 1'b0;
      chg_rcvd_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      paid_q      <= paid_d;
      gap_q       <= gap_d;
      timer_q     <= timer_d;
      chg_flag_q  <= chg_flag_d;
      chg_rcvd_q  <= chg_rcvd_d;
    end
  end

  // Mode 2 always pays one-yuan (may overpay); modes 0/3 are greedy; mode 1 is half-only.
  always_comb begin
    one_sel = (mode_q == 2'd2) || ((mode_q != 2'd1) && (remaining_q >= 4'd2));
    if (one_sel) begin
      coin_rem = (remaining_q >= 4'd2) ? (remaining_q - 4'd2) : 4'd0;
    end else begin
      coin_rem = remaining_q - 4'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    paid_d      = paid_q;
    gap_d       = gap_q;
    timer_d     = timer_q;
    chg_flag_d  = chg_flag_q;
    chg_rcvd_d  = chg_rcvd_q;
    case (state_q)
      S_IDLE: begin
        if (buy_req) begin
          mode_d      = pay_mode;
          remaining_d = 4'(PRICE);
          paid_d      = 5'd0;
          chg_flag_d  = 1'b0;
          chg_rcvd_d  = 1'b0;
          state_d     = S_COIN;
        end
      end
      S_COIN: begin
        remaining_d = coin_rem;
        paid_d      = paid_q + (one_sel ? 5'd2 : 5'd1);
        if (coin_rem == 4'd0) begin
          timer_d = 8'd0;
          state_d = S_WAIT_COLA;
        end else if (GAP_CYC > 0) begin
          gap_d   = 4'd0;
          state_d = S_GAP;
        end else begin
          state_d = S_COIN;
        end
      end
      S_GAP: begin
        if (gap_q == 4'(GAP_CYC - 1)) begin
          state_d = S_COIN;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      S_WAIT_COLA: begin
        if (pi_money) begin
          chg_flag_d = 1'b1;
        end
        if (pi_cola) begin
          chg_rcvd_d = chg_flag_q | pi_money;
          state_d    = S_DONE;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          chg_rcvd_d = 1'b0;
          state_d    = S_ERR;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    po_money_one  = (state_q == S_COIN) && one_sel;
    po_money_half = (state_q == S_COIN) && !one_sel;
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    err           = (state_q == S_ERR);
    change_rcvd   = chg_rcvd_q;
    paid_units    = paid_q;
  end

`ifdef COIN_STAT_EN
  logic [15:0] stat_half_q, stat_half_d;
  logic [15:0] stat_one_q, stat_one_d;
  logic [15:0] stat_cola_q, stat_cola_d;

  always_comb begin
    stat_half_d = stat_half_q + (po_money_half ? 16'd1 : 16'd0);
    stat_one_d  = stat_one_q + (po_money_one ? 16'd1 : 16'd0);
    stat_cola_d = stat_cola_q + (done ? 16'd1 : 16'd0);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      stat_half_q <= 16'd0;
      stat_one_q  <= 16'd0;
      stat_cola_q <= 16'd0;
    end else begin
      stat_half_q <= stat_half_d;
      stat_one_q  <= stat_one_d;
      stat_cola_q <= stat_cola_d;
    end
  end

  assign stat_half_cnt = stat_half_q;
  assign stat_one_cnt  = stat_one_q;
  assign stat_cola_cnt = stat_cola_q;
`else
  assign stat_half_cnt = 16'd0;
  assign stat_one_cnt  = 16'd0;
  assign stat_cola_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cola_buyer_fsm.sv
// Scoreboard bench for cola_buyer_fsm: expected coin/done/err events are queued by the stimulus,
// and a monitor pops and checks them whenever the DUT pulses an output.
module tb_cola_buyer_fsm;

  localparam int unsigned PRICE   = 5;
  localparam int unsigned GAP_CYC = 2;
  localparam int unsigned TIMEOUT = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        buy_req;
  logic [1:0]  pay_mode;
  logic        pi_cola;
  logic        pi_money;
  logic        po_money_half;
  logic        po_money_one;
  logic        busy;
  logic        done;
  logic        err;
  logic        change_rcvd;
  logic [4:0]  paid_units;
  logic [15:0] stat_half_cnt;
  logic [15:0] stat_one_cnt;
  logic [15:0] stat_cola_cnt;

  typedef enum int {EV_ONE = 1, EV_HALF = 2, EV_DONE = 3, EV_ERR = 4} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    int         cyc;
    logic [4:0] paid;
    logic       chg;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  base;

  cola_buyer_fsm #(
    .PRICE   (PRICE),
    .GAP_CYC (GAP_CYC),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .buy_req       (buy_req),
    .pay_mode      (pay_mode),
    .pi_cola       (pi_cola),
    .pi_money      (pi_money),
    .po_money_half (po_money_half),
    .po_money_one  (po_money_one),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .change_rcvd   (change_rcvd),
    .paid_units    (paid_units),
    .stat_half_cnt (stat_half_cnt),
    .stat_one_cnt  (stat_one_cnt),
    .stat_cola_cnt (stat_cola_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic applyStimulus(input logic buy, input logic [1:0] mode, input logic cola, input logic money);
    buy_req  = buy;
    pay_mode = mode;
    pi_cola  = cola;
    pi_money = money;
  endtask

  task automatic push_ev(input ev_kind_t kind, input int c, input logic [4:0] paid, input logic chg);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.paid = paid;
    e.chg  = chg;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  task automatic pulse_reset();
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
  endtask

  // Monitor: every coin/done/err pulse must match the head of the expected-event queue.
  always @(negedge sys_clk) begin : monitor
    ev_t      e;
    ev_kind_t k;
    if (!sys_rst && (po_money_one || po_money_half || done || err)) begin
      if (po_money_one || po_money_half)
        checkOutput("coin_exclusive", 32'(po_money_one & po_money_half), 32'd0);
      if (po_money_one)       k = EV_ONE;
      else if (po_money_half) k = EV_HALF;
      else if (done)          k = EV_DONE;
      else                    k = EV_ERR;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_event at cycle %0d: got kind %0d, expected none", cyc, int'(k));
      end else begin
        e = exp_q.pop_front();
        checkOutput("event_kind", 32'(k), 32'(e.kind));
        checkOutput("event_cycle", 32'(cyc), 32'(e.cyc));
        if (e.kind == EV_DONE) begin
          checkOutput("done_paid_units", 32'(paid_units), 32'(e.paid));
          checkOutput("done_change_rcvd", 32'(change_rcvd), 32'(e.chg));
        end
        if (e.kind == EV_ERR) begin
          checkOutput("err_change_rcvd", 32'(change_rcvd), 32'd0);
          checkOutput("err_no_done", 32'(done), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d: got no finish, expected finish", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    sys_rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(negedge sys_clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_coins", 32'({po_money_one, po_money_half}), 32'd0);
    checkOutput("rst_done_err", 32'({done, err}), 32'd0);
    checkOutput("rst_paid_units", 32'(paid_units), 32'd0);
    checkOutput("rst_change_rcvd", 32'(change_rcvd), 32'd0);
    checkOutput("rst_stats", 32'(stat_one_cnt | stat_half_cnt | stat_cola_cnt), 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Mode 0 greedy: one, one, half; cola at +9.
    base = cyc;
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    push_ev(EV_ONE, base + 1, 5'd0, 1'b0);
    push_ev(EV_ONE, base + 4, 5'd0, 1'b0);
    push_ev(EV_HALF, base + 7, 5'd0, 1'b0);
    push_ev(EV_DONE, base + 10, 5'd5, 1'b0);
    wait_to(base + 1);  applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    wait_to(base + 5);  checkOutput("m0_busy_gap", 32'(busy), 32'd1);
    wait_to(base + 9);  applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    wait_to(base + 10); applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    wait_to(base + 11);
    checkOutput("m0_idle_busy", 32'(busy), 32'd0);
    checkOutput("m0_paid_hold", 32'(paid_units), 32'd5);

    // Mode 1 half-only; change pulse during GAP must be ignored.
    @(negedge sys_clk);
    base = cyc;
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) push_ev(EV_HALF, base + 1 + 3 * i, 5'd0, 1'b0);
    push_ev(EV_DONE, base + 16, 5'd5, 1'b0);
    wait_to(base + 1);  applyStimulus(1'b0, 2'd1, 1'b0, 1'b0);
    wait_to(base + 2);  applyStimulus(1'b0, 2'd1, 1'b0, 1'b1);
    wait_to(base + 3);  applyStimulus(1'b0, 2'd1, 1'b0, 1'b0);
    wait_to(base + 14); checkOutput("m1_wait_busy", 32'(busy), 32'd1);
    wait_to(base + 15); applyStimulus(1'b0, 2'd1, 1'b1, 1'b0);
    wait_to(base + 16); applyStimulus(1'b0, 2'd1, 1'b0, 1'b0);
    wait_to(base + 17); checkOutput("m1_change_hold", 32'(change_rcvd), 32'd0);

    // Mode 2 one-only overpays to 6; cola and change together.
    @(negedge sys_clk);
    base = cyc;
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push_ev(EV_ONE, base + 1 + 3 * i, 5'd0, 1'b0);
    push_ev(EV_DONE, base + 10, 5'd6, 1'b1);
    wait_to(base + 1);  applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    wait_to(base + 9);  applyStimulus(1'b0, 2'd2, 1'b1, 1'b1);
    wait_to(base + 10); applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    wait_to(base + 11);
    checkOutput("m2_change_hold", 32'(change_rcvd), 32'd1);
    checkOutput("m2_paid_hold", 32'(paid_units), 32'd6);

    // Timeout: no cola, change alone does not complete; err at +24.
    @(negedge sys_clk);
    base = cyc;
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    push_ev(EV_ONE, base + 1, 5'd0, 1'b0);
    push_ev(EV_ONE, base + 4, 5'd0, 1'b0);
    push_ev(EV_HALF, base + 7, 5'd0, 1'b0);
    push_ev(EV_ERR, base + 24, 5'd0, 1'b0);
    wait_to(base + 1);  applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    wait_to(base + 12); applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    wait_to(base + 13); applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    wait_to(base + 23); checkOutput("to_busy_last_wait", 32'(busy), 32'd1);
    wait_to(base + 25);
    checkOutput("to_idle_busy", 32'(busy), 32'd0);
    checkOutput("to_paid_hold", 32'(paid_units), 32'd5);

    // Reset during GAP aborts at once; next purchase pays the full price again.
    @(negedge sys_clk);
    base = cyc;
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    push_ev(EV_ONE, base + 1, 5'd0, 1'b0);
    wait_to(base + 1);  applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    wait_to(base + 2);
    sys_rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_paid_units", 32'(paid_units), 32'd0);
    checkOutput("abort_coins", 32'({po_money_one, po_money_half}), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    base = cyc;
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    push_ev(EV_ONE, base + 1, 5'd0, 1'b0);
    push_ev(EV_ONE, base + 4, 5'd0, 1'b0);
    push_ev(EV_HALF, base + 7, 5'd0, 1'b0);
    push_ev(EV_DONE, base + 10, 5'd5, 1'b0);
    wait_to(base + 1);  applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    wait_to(base + 9);  applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    wait_to(base + 10); applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    wait_to(base + 12);

    // buy_req held high: second purchase starts only from IDLE; cola in IDLE ignored.
    pulse_reset();
    base = cyc;
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    push_ev(EV_ONE, base + 1, 5'd0, 1'b0);
    push_ev(EV_ONE, base + 4, 5'd0, 1'b0);
    push_ev(EV_HALF, base + 7, 5'd0, 1'b0);
    push_ev(EV_DONE, base + 10, 5'd5, 1'b0);
    push_ev(EV_ONE, base + 12, 5'd0, 1'b0);
    push_ev(EV_ONE, base + 15, 5'd0, 1'b0);
    push_ev(EV_HALF, base + 18, 5'd0, 1'b0);
    push_ev(EV_DONE, base + 21, 5'd5, 1'b0);
    wait_to(base + 9);  applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
    wait_to(base + 10); applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    wait_to(base + 20); applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
    wait_to(base + 21); applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    wait_to(base + 23); applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
    wait_to(base + 24); applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    wait_to(base + 27);
    checkOutput("held_idle_busy", 32'(busy), 32'd0);
`ifdef COIN_STAT_EN
    checkOutput("stat_one_cnt", 32'(stat_one_cnt), 32'd4);
    checkOutput("stat_half_cnt", 32'(stat_half_cnt), 32'd2);
    checkOutput("stat_cola_cnt", 32'(stat_cola_cnt), 32'd2);
`else
    checkOutput("stat_one_cnt", 32'(stat_one_cnt), 32'd0);
    checkOutput("stat_half_cnt", 32'(stat_half_cnt), 32'd0);
    checkOutput("stat_cola_cnt", 32'(stat_cola_cnt), 32'd0);
`endif

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cola_buyer_fsm.md
Name: cola_buyer_fsm

Overview:
- Customer-side coin payer: the initiator end of the cola vending interface.
- On a buy request, generates single-cycle half-yuan or one-yuan coin pulses until PRICE is covered, then waits for the machine's cola and change pulses.
- Reports done or timeout.
- Drives pi_money_half/pi_money_one of the vending FSM and consumes its po_cola/po_money.

Parameters:
- PRICE, 5, cola price in half-yuan units (legal range 1..15).
- GAP_CYC, 2, idle cycles between consecutive coin pulses (0..15).
- TIMEOUT, 16, cycles allowed in WAIT_COLA before error (1..255).

Ports:
- sys_clk  input  1  system clock, all logic on rising edge.
- sys_rst  input  1  asynchronous active-high reset.
- buy_req  input  1  start purchase; sampled only in IDLE.
- pay_mode  input  2  0 = greedy (one-yuan while remaining >= 2, else half); 1 = half only; 2 = one only (overpay allowed); 3 = treated as 0.
- pi_cola  input  1  cola pulse from vending machine.
- pi_money  input  1  change pulse from vending machine.
- po_money_half  output  1  half-yuan coin pulse.
- po_money_one  output  1  one-yuan coin pulse.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse, purchase completed.
- err  output  1  one-cycle pulse, cola timeout.
- change_rcvd  output  1  valid with done: change was seen.
- paid_units  output  5  half-yuan units paid in the current or last purchase.
- stat_half_cnt, stat_one_cnt, stat_cola_cnt  output  16 each  statistics (see Optional Feature).

Behaviour:
- Clock and reset: one clock, sys_clk; reset is asynchronous and active-high on sys_rst.
- Reset: state = IDLE; all outputs, remaining, gap/timeout counters and change flag are 0.
- States: IDLE, COIN, GAP, WAIT_COLA, DONE, ERR.
- IDLE:
  - buy_req = 1 at an edge: latch pay_mode, remaining = PRICE, paid_units = 0, change flag = 0, next = COIN.
- COIN (exactly one cycle). Exactly one of po_money_one/po_money_half is high for this cycle; never both.
  - One-yuan pulse when (mode 0/3 and remaining >= 2) or mode 2: remaining -= 2, saturating at 0; paid_units += 2.
  - Otherwise a half-yuan pulse: remaining -= 1; paid_units += 1.
  - Next state: WAIT_COLA if updated remaining = 0; else GAP if GAP_CYC > 0; else COIN.
- GAP: hold for GAP_CYC cycles, coin outputs low, then COIN. Coin pulses are therefore spaced GAP_CYC+1 cycles apart.
- WAIT_COLA:
  - Timer starts at 0 on entry.
  - pi_money = 1 in any WAIT_COLA cycle sets the change flag.
  - pi_cola = 1 goes to DONE; pi_money in the same cycle still counts as change.
  - After TIMEOUT WAIT_COLA cycles without cola, go to ERR.
- DONE: done = 1 for one cycle; change_rcvd = change flag (held until the next buy); next = IDLE.
- ERR: err = 1 for one cycle; change_rcvd = 0; next = IDLE.
- Ignored inputs:
  - buy_req outside IDLE is ignored, not queued.
  - pi_cola/pi_money outside WAIT_COLA are ignored.
- Reset mid-operation aborts immediately; no partial coin pulse. The next purchase pays the full PRICE again.
- paid_units holds its value after DONE/ERR until the next accepted buy_req.

Optional Feature:
- Macro: COIN_STAT_EN.
- Defined:
  - stat_half_cnt and stat_one_cnt increment on each emitted coin pulse.
  - stat_cola_cnt increments on each DONE.
  - All three are 16-bit, wrap 0xFFFF to 0, and clear only on sys_rst.
- Undefined: the three stat ports are tied to 0 and no counters are synthesized.

Test Plan:
- PRICE=5, GAP_CYC=2, mode 0, buy_req at cycle 0 -> one pulses at cycles 1 and 4, half pulse at 7, WAIT_COLA from 8. pi_cola at 9 -> done at 10, paid_units=5, change_rcvd=0.
- Mode 1, buy_req at cycle 0 -> half pulses at cycles 1, 4, 7, 10, 13; po_money_one never high; paid_units=5.
- Mode 2 -> one pulses at cycles 1, 4, 7; paid_units=6. pi_cola and pi_money together at 9 -> done at 10, change_rcvd=1.
- Mode 0 with no pi_cola -> WAIT_COLA cycles 8..23, err at 24, done never high, busy low at 25.
- sys_rst pulsed at cycle 2 (in GAP after the first coin) -> outputs 0 immediately. New buy_req -> full coin sequence restarts (one, one, half).
- buy_req held high throughout -> a second purchase starts only from IDLE after done. pi_cola in IDLE -> no done. With COIN_STAT_EN, after two mode-0 purchases: stat_one_cnt=4, stat_half_cnt=2, stat_cola_cnt=2.
